// File: rtl/vga_timing_pkg.sv
// Purpose : shared constants and state type for the VGA timing generator.
// Latency : n/a (package only).
// Backpressure : n/a; holds the 640x480@60 defaults, derived totals and the FSM state type.
package vga_timing_pkg;

    // 640x480@60 horizontal timing, in pixels
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    localparam int LOCK_CYCLES_DEF = 16;

    // Width of hcount/vcount; both totals must fit in it.
    localparam int CNT_W = 10;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

endpackage

// File: rtl/lock_qual.sv
// Purpose : synchronises pll_locked and qualifies it as stable for LOCK_CYCLES cycles.
// Latency : 2 cycles into lock_sync; lock_ok asserts on the LOCK_CYCLES-th consecutive high lock_sync cycle.
// Backpressure : none; free-running. Ports: clk, rst, pll_locked -> lock_sync, lock_ok.
module lock_qual #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_sync,
    output logic lock_ok
);

    localparam int SW = $clog2(LOCK_CYCLES + 1);
    localparam logic [SW-1:0] LAST = SW'(LOCK_CYCLES - 1);

    logic          lock_meta;
    logic [SW-1:0] stable_cnt;

    // stable_cnt holds the number of earlier consecutive high lock_sync cycles,
    // saturating at LOCK_CYCLES-1 so lock_ok stays up while the lock holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta  <= 1'b0;
            lock_sync  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            if (!lock_sync) begin
                stable_cnt <= '0;
            end else if (stable_cnt != LAST) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // Asserted in the cycle that completes the run of LOCK_CYCLES high samples.
    assign lock_ok = lock_sync && (stable_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing (counters, de, syncs, line/frame pulses) gated by a qualified PLL lock.
// Latency : all outputs registered; first RUN cycle presents (0,0) with both pulses; loss of lock clears outputs 3 edges later.
// Backpressure : none; free-running at pixel rate. Ports: clk, rst, pll_locked -> running, hcount, vcount, de, hs_n, vs_n, line_start, frame_start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             running,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             de,
    output logic             hs_n,
    output logic             vs_n,
    output logic             line_start,
    output logic             frame_start
);

    // All raster arithmetic is done on CNT_W-bit unsigned values.
    localparam logic [CNT_W-1:0] H_TOTAL  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_TOTAL  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_LAST   = H_TOTAL - CNT_W'(1);
    localparam logic [CNT_W-1:0] V_LAST   = V_TOTAL - CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic lock_sync;
    logic lock_ok;

    lock_qual #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_qual (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .lock_sync  (lock_sync),
        .lock_ok    (lock_ok)
    );

    vga_state_e       state;
    vga_state_e       state_nxt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             run_nxt;
    logic             de_nxt;
    logic             hs_n_nxt;
    logic             vs_n_nxt;
    logic             ls_nxt;
    logic             fs_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next raster position. Anything other than staying in RUN yields (0,0),
    // which is both the idle value and the first position of a new run.
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        case (state)
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_nxt = WAIT_LOCK;
                end else if (hcount == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
                end else begin
                    h_nxt = hcount + CNT_W'(1);
                    v_nxt = vcount;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Decode from the next position so every registered output describes the
    // same hcount/vcount it is presented with.
    always_comb begin
        run_nxt  = (state_nxt == RUN);
        de_nxt   = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_n_nxt = !(run_nxt && (h_nxt >= HS_BEGIN) && (h_nxt < HS_END));
        vs_n_nxt = !(run_nxt && (v_nxt >= VS_BEGIN) && (v_nxt < VS_END));
        ls_nxt   = run_nxt && (h_nxt == '0);
        fs_nxt   = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            de          <= 1'b0;
            hs_n        <= 1'b1;
            vs_n        <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= run_nxt;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            de          <= de_nxt;
            hs_n        <= hs_n_nxt;
            vs_n        <= vs_n_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : randomized scoreboard bench for vga_timing_gen against a raster-arithmetic reference model.
// Latency : expected output pushed at each clock edge, popped and compared on the following falling edge.
// Backpressure : none; a reduced raster keeps multi-frame runs short.
module tb_vga_timing_gen;

    localparam int HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int LC = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       running;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       de;
    logic       hs_n;
    logic       vs_n;
    logic       line_start;
    logic       frame_start;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .running     (running),
        .hcount      (hcount),
        .vcount      (vcount),
        .de          (de),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic       run;
        logic [9:0] h;
        logic [9:0] v;
        logic       de;
        logic       hs_n;
        logic       vs_n;
        logic       ls;
        logic       fs;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    // pll_hist holds pll_locked as sampled at each edge since reset; the value
    // the timing logic acts on at an edge is the one sampled two edges earlier.
    bit pll_hist[$];
    int streak = 0;      // consecutive high synchronized samples while waiting
    bit m_run  = 0;
    int t      = 0;      // cycles since the current run began

    task automatic model_edge(input bit r, input bit p);
        bit d;
        if (r) begin
            pll_hist.delete();
            streak = 0;
            m_run  = 0;
            t      = 0;
            return;
        end
        d = (pll_hist.size() >= 2) ? pll_hist[pll_hist.size()-2] : 1'b0;
        pll_hist.push_back(p);
        if (pll_hist.size() > 4) void'(pll_hist.pop_front());
        if (!m_run) begin
            if (d) begin
                streak++;
                if (streak == LC) begin
                    m_run = 1;
                    t     = 0;
                end
            end else begin
                streak = 0;
            end
        end else if (!d) begin
            m_run  = 0;
            streak = 0;
        end else begin
            t++;
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        int   h;
        int   v;
        e = '{run: 1'b0, h: 10'd0, v: 10'd0, de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, ls: 1'b0, fs: 1'b0};
        if (m_run) begin
            h      = t % HT;
            v      = (t / HT) % VT;
            e.run  = 1'b1;
            e.h    = 10'(h);
            e.v    = 10'(v);
            e.de   = (h < HA) && (v < VA);
            e.hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
            e.ls   = (h == 0);
            e.fs   = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    // One clock edge: apply the model to the inputs the DUT sampled, queue the
    // expected outputs, and return just after the edge.
    task automatic step();
        @(posedge clk);
        model_edge(rst, pll_locked);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit fr_valid = 0;
    int fr_cyc, fr_de, fr_ls, fr_hs, fr_vs;

    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{run: running, h: hcount, v: vcount, de: de, hs_n: hs_n,
                  vs_n: vs_n, ls: line_start, fs: frame_start};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL cycle_check at %0t: got run=%b h=%0d v=%0d de=%b hs_n=%b vs_n=%b ls=%b fs=%b expected run=%b h=%0d v=%0d de=%b hs_n=%b vs_n=%b ls=%b fs=%b",
                         $time, g.run, g.h, g.v, g.de, g.hs_n, g.vs_n, g.ls, g.fs,
                         e.run, e.h, e.v, e.de, e.hs_n, e.vs_n, e.ls, e.fs);
            end
        end
        // Whole-frame totals, measured between consecutive frame_start pulses
        // of one uninterrupted run.
        if (running !== 1'b1) begin
            fr_valid = 0;
        end else begin
            if (frame_start === 1'b1) begin
                if (fr_valid) begin
                    chk("frame_period", fr_cyc, FRAME);
                    chk("frame_de_cycles", fr_de, HA * VA);
                    chk("frame_line_starts", fr_ls, VT);
                    chk("frame_hsync_cycles", fr_hs, HS * VT);
                    chk("frame_vsync_cycles", fr_vs, VS * HT);
                end
                fr_valid = 1;
                fr_cyc = 0; fr_de = 0; fr_ls = 0; fr_hs = 0; fr_vs = 0;
            end
            fr_cyc++;
            fr_de += int'(de);
            fr_ls += int'(line_start);
            fr_hs += int'(!hs_n);
            fr_vs += int'(!vs_n);
        end
    end

    // ---------------- stimulus ----------------
    task automatic count_to_running(input int bound, output int n);
        n = 0;
        while (running !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic run_to(input int hh, input int vv, input int bound, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < bound) begin
            if (running === 1'b1 && int'(hcount) == hh && int'(vcount) == vv) begin
                ok = 1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_running"}, int'(running), 0);
        chk({name, "_hcount"}, int'(hcount), 0);
        chk({name, "_vcount"}, int'(vcount), 0);
        chk({name, "_de"}, int'(de), 0);
        chk({name, "_hs_n"}, int'(hs_n), 1);
        chk({name, "_vs_n"}, int'(vs_n), 1);
    endtask

    initial begin
        int n;
        bit ok;
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        chk_idle("reset_state");

        // Release with the PLL already locked: 2 sync + 16 qualify cycles.
        pll_locked = 1'b1;
        rst        = 1'b0;
        count_to_running(60, n);
        chk("lock_latency", n, 2 + LC);
        chk("first_hcount", int'(hcount), 0);
        chk("first_vcount", int'(vcount), 0);
        chk("first_frame_start", int'(frame_start), 1);
        chk("first_line_start", int'(line_start), 1);
        chk("first_de", int'(de), 1);

        // Two full frames, then the raster corners.
        repeat (2 * FRAME + 5) step();
        run_to(HT - 1, VT - 1, FRAME + 10, ok);
        chk("reach_last_pixel", int'(ok), 1);
        step();
        chk("wrap_hcount", int'(hcount), 0);
        chk("wrap_vcount", int'(vcount), 0);
        chk("wrap_frame_start", int'(frame_start), 1);
        run_to(HT - 1, 5, FRAME + 10, ok);
        chk("reach_line_end", int'(ok), 1);
        step();
        chk("line_wrap_vcount", int'(vcount), 6);
        chk("line_wrap_frame_start", int'(frame_start), 0);

        // Lock lost mid-frame: idle values within three edges.
        run_to(30, 10, FRAME + 10, ok);
        chk("reach_mid_frame", int'(ok), 1);
        pll_locked = 1'b0;
        repeat (3) step();
        chk_idle("lock_drop");

        // One-cycle glitch part-way through qualification restarts the count.
        pll_locked = 1'b1;
        repeat (12) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        count_to_running(60, n);
        chk("glitch_requalify", n, 2 + LC);

        // Asynchronous reset between edges, then full requalification.
        repeat (100) step();
        #5;
        rst = 1'b1;
        #1;
        chk_idle("async_reset");
        step();
        step();
        rst = 1'b0;
        count_to_running(60, n);
        chk("reset_requalify", n, 2 + LC);

        // Randomized mix of long runs, lock glitches, chatter and reset pulses.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    pll_locked = 1'b1;
                    repeat ($urandom_range(20, 1500)) step();
                end
                1: begin
                    pll_locked = 1'b0;
                    repeat ($urandom_range(1, 4)) step();
                    pll_locked = 1'b1;
                end
                2: begin
                    for (int k = 0; k < 12; k++) begin
                        pll_locked = 1'($urandom_range(0, 1));
                        step();
                    end
                    pll_locked = 1'b1;
                end
                default: begin
                    #5;
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                end
            endcase
        end
        pll_locked = 1'b1;
        repeat (40) step();
        #10;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
